// File: rtl/tetris_board_renderer_if.sv
// Pixel-stage bundle: raw timing in, board RAM read port, and aligned RGB/sync out.
// The renderer sits on the slave side; the sync generator / RAM / VGA side is master.
interface tetris_board_renderer_if;
   logic       iBLANK_n;
   logic       iHS;
   logic       iVS;
   logic [7:0] oCELL_ADDR;
   logic [2:0] iCELL_DATA;
   logic [3:0] oVGA_R;
   logic [3:0] oVGA_G;
   logic [3:0] oVGA_B;
   logic       oHS;
   logic       oVS;
   logic       oBLANK_n;

   modport master (
      output iBLANK_n, iHS, iVS, iCELL_DATA,
      input  oCELL_ADDR, oVGA_R, oVGA_G, oVGA_B, oHS, oVS, oBLANK_n
   );

   modport slave (
      input  iBLANK_n, iHS, iVS, iCELL_DATA,
      output oCELL_ADDR, oVGA_R, oVGA_G, oVGA_B, oHS, oVS, oBLANK_n
   );
endinterface

// File: rtl/tetris_board_renderer.sv
// Tetris board pixel-colour stage: tracks x/y from raw timing, reads board cells,
// maps them through the tetromino palette; RGB and syncs leave 3 cycles after input.
module tetris_board_renderer #(
   parameter int          BOARD_X0   = 220,
   parameter int          BOARD_Y0   = 40,
   parameter int          CELL_PX    = 20,
   parameter int          COLS       = 10,
   parameter int          ROWS       = 20,
   parameter int          BORDER_PX  = 4,
   parameter logic [11:0] BORDER_RGB = 12'hAAA,
   parameter logic [11:0] GRID_RGB   = 12'h222,
   parameter logic [11:0] BG_RGB     = 12'h000
) (
   input  logic                    iVGA_CLK,
   input  logic                    iRST_n,
   tetris_board_renderer_if.slave  vga
);

   localparam logic [9:0] X0_C       = 10'(BOARD_X0);
   localparam logic [9:0] X1_C       = 10'(BOARD_X0 + COLS * CELL_PX);
   localparam logic [9:0] FX0_C      = 10'(BOARD_X0 - BORDER_PX);
   localparam logic [9:0] FX1_C      = 10'(BOARD_X0 + COLS * CELL_PX + BORDER_PX);
   localparam logic [9:0] Y0_C       = 10'(BOARD_Y0);
   localparam logic [9:0] Y1_C       = 10'(BOARD_Y0 + ROWS * CELL_PX);
   localparam logic [9:0] FY0_C      = 10'(BOARD_Y0 - BORDER_PX);
   localparam logic [9:0] FY1_C      = 10'(BOARD_Y0 + ROWS * CELL_PX + BORDER_PX);
   localparam logic [5:0] SUB_LAST_C = 6'(CELL_PX - 1);
   localparam logic [7:0] COL_LAST_C = 8'(COLS - 1);
   localparam logic [7:0] ROW_LAST_C = 8'(ROWS - 1);
   localparam logic [7:0] COLS_C     = 8'(COLS);

   function automatic logic [11:0] cellColour(input logic [2:0] code);
      logic [11:0] colour;
      case (code)
         3'd1:    colour = 12'h0FF;
         3'd2:    colour = 12'hFF0;
         3'd3:    colour = 12'hF0F;
         3'd4:    colour = 12'h0F0;
         3'd5:    colour = 12'hF00;
         3'd6:    colour = 12'h00F;
         3'd7:    colour = 12'hF80;
         default: colour = BG_RGB;
      endcase
      return colour;
   endfunction

   logic [9:0]  xCnt_r, yCnt_r;
   logic        blankPrev_r, synced_r;
   logic [5:0]  subX_r, subY_r;
   logic [7:0]  col_r, row_r;
   logic [5:0]  subXCur_s, subYCur_s, subXNext_s, subYNext_s;
   logic [7:0]  colCur_s, rowCur_s, colNext_s, rowNext_s;
   logic        lineEnd_s, visible_s, xInBoard_s, yInBoard_s, xInFrame_s, yInFrame_s;
   logic        inBoard_s, inFrame_s, grid_s;
   logic [7:0]  addr_s;
   logic [7:0]  addr_r;
   logic        inBoard1_r, inFrame1_r, grid1_r, vis1_r;
   logic        inBoard2_r, inFrame2_r, grid2_r, vis2_r;
   logic [11:0] rgbNext_s, rgb_r;
   logic [2:0]  hsDly_r, vsDly_r, blankDly_r;

   // Current cell position: sub counters restart whenever the board edge is reached.
   always_comb begin
      subXCur_s = subX_r;
      colCur_s  = col_r;
      subYCur_s = subY_r;
      rowCur_s  = row_r;
      if (xCnt_r == X0_C) begin
         subXCur_s = 6'd0;
         colCur_s  = 8'd0;
      end else begin
         subXCur_s = subX_r;
         colCur_s  = col_r;
      end
      if (yCnt_r == Y0_C) begin
         subYCur_s = 6'd0;
         rowCur_s  = 8'd0;
      end else begin
         subYCur_s = subY_r;
         rowCur_s  = row_r;
      end
   end

   // Next cell position: wrap the sub counter, saturate col/row at the last cell.
   always_comb begin
      subXNext_s = subXCur_s + 6'd1;
      colNext_s  = colCur_s;
      subYNext_s = subYCur_s + 6'd1;
      rowNext_s  = rowCur_s;
      if (subXCur_s == SUB_LAST_C) begin
         subXNext_s = 6'd0;
         if (colCur_s != COL_LAST_C) colNext_s = colCur_s + 8'd1;
         else                        colNext_s = colCur_s;
      end else begin
         subXNext_s = subXCur_s + 6'd1;
      end
      if (subYCur_s == SUB_LAST_C) begin
         subYNext_s = 6'd0;
         if (rowCur_s != ROW_LAST_C) rowNext_s = rowCur_s + 8'd1;
         else                        rowNext_s = rowCur_s;
      end else begin
         subYNext_s = subYCur_s + 6'd1;
      end
   end

   // Region classification of the incoming pixel; nothing is drawn until y is synchronised.
   always_comb begin
      lineEnd_s  = blankPrev_r & ~vga.iBLANK_n;
      visible_s  = vga.iBLANK_n & synced_r;
      xInBoard_s = (xCnt_r >= X0_C) && (xCnt_r < X1_C);
      yInBoard_s = (yCnt_r >= Y0_C) && (yCnt_r < Y1_C);
      xInFrame_s = (xCnt_r >= FX0_C) && (xCnt_r < FX1_C);
      yInFrame_s = (yCnt_r >= FY0_C) && (yCnt_r < FY1_C);
      inBoard_s  = visible_s & xInBoard_s & yInBoard_s;
      inFrame_s  = visible_s & xInFrame_s & yInFrame_s & ~(xInBoard_s & yInBoard_s);
      grid_s     = inBoard_s & ((subXCur_s == SUB_LAST_C) | (subYCur_s == SUB_LAST_C));
      if (inBoard_s) addr_s = rowCur_s * COLS_C + colCur_s;
      else           addr_s = 8'd0;
   end

   // Stage 0 counters: x per active pixel, y and row per line end, y cleared by vsync.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         xCnt_r      <= 10'd0;
         yCnt_r      <= 10'd0;
         blankPrev_r <= 1'b0;
         synced_r    <= 1'b0;
         subX_r      <= 6'd0;
         col_r       <= 8'd0;
         subY_r      <= 6'd0;
         row_r       <= 8'd0;
      end else begin
         blankPrev_r <= vga.iBLANK_n;
         if (vga.iBLANK_n) begin
            xCnt_r <= xCnt_r + 10'd1;
            subX_r <= subXNext_s;
            col_r  <= colNext_s;
         end else begin
            xCnt_r <= 10'd0;
         end
         if (!vga.iVS) begin
            yCnt_r   <= 10'd0;
            synced_r <= 1'b1;
         end else if (lineEnd_s) begin
            yCnt_r <= yCnt_r + 10'd1;
         end
         if (lineEnd_s) begin
            subY_r <= subYNext_s;
            row_r  <= rowNext_s;
         end
      end
   end

   // Stages 1 and 2: RAM address out, region flags follow the RAM read latency.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         addr_r     <= 8'd0;
         inBoard1_r <= 1'b0;
         inFrame1_r <= 1'b0;
         grid1_r    <= 1'b0;
         vis1_r     <= 1'b0;
         inBoard2_r <= 1'b0;
         inFrame2_r <= 1'b0;
         grid2_r    <= 1'b0;
         vis2_r     <= 1'b0;
      end else begin
         addr_r     <= addr_s;
         inBoard1_r <= inBoard_s;
         inFrame1_r <= inFrame_s;
         grid1_r    <= grid_s;
         vis1_r     <= visible_s;
         inBoard2_r <= inBoard1_r;
         inFrame2_r <= inFrame1_r;
         grid2_r    <= grid1_r;
         vis2_r     <= vis1_r;
      end
   end

   // Stage 3 colour selection from the flags and the returned cell code.
   always_comb begin
      rgbNext_s = BG_RGB;
      if (!vis2_r) begin
         rgbNext_s = 12'h000;
      end else if (inFrame2_r) begin
         rgbNext_s = BORDER_RGB;
      end else if (inBoard2_r) begin
         if (vga.iCELL_DATA == 3'd0) begin
            if (grid2_r) rgbNext_s = GRID_RGB;
            else         rgbNext_s = BG_RGB;
         end else begin
            rgbNext_s = cellColour(vga.iCELL_DATA);
         end
      end else begin
         rgbNext_s = BG_RGB;
      end
   end

   // Stage 3 output register plus the matching 3-tap sync/blank delays.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         rgb_r      <= 12'h000;
         hsDly_r    <= 3'b111;
         vsDly_r    <= 3'b111;
         blankDly_r <= 3'b000;
      end else begin
         rgb_r      <= rgbNext_s;
         hsDly_r    <= {hsDly_r[1:0], vga.iHS};
         vsDly_r    <= {vsDly_r[1:0], vga.iVS};
         blankDly_r <= {blankDly_r[1:0], vga.iBLANK_n};
      end
   end

   assign vga.oCELL_ADDR = addr_r;
   assign vga.oVGA_R     = rgb_r[11:8];
   assign vga.oVGA_G     = rgb_r[7:4];
   assign vga.oVGA_B     = rgb_r[3:0];
   assign vga.oHS        = hsDly_r[2];
   assign vga.oVS        = vsDly_r[2];
   assign vga.oBLANK_n   = blankDly_r[2];

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Scoreboard bench: a line/frame generator with a random board feeds the renderer; a
// coordinate-level model predicts every output pixel and a monitor compares them.
module tb_tetris_board_renderer;

   logic clk;
   logic rstN;

   tetris_board_renderer_if ifc();

   tetris_board_renderer dut (
      .iVGA_CLK (clk),
      .iRST_n   (rstN),
      .vga      (ifc)
   );

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        bl;
      logic [7:0]  addr;
   } exp_t;

   exp_t        expQ[$];
   exp_t        monE;
   logic [2:0]  cells [200];
   logic [11:0] pal [8];
   logic [7:0]  prevAddr;
   bit          synced;
   bit          monOn;
   int          nCmp;
   int          nFail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nCmp++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Board RAM: data for an address appears one cycle after the address is presented.
   initial begin
      prevAddr        = 8'd0;
      ifc.iCELL_DATA  = 3'd0;
      forever begin
         @(negedge clk);
         ifc.iCELL_DATA = cells[prevAddr];
         prevAddr       = ifc.oCELL_ADDR;
      end
   end

   // Monitor: address one cycle after a pixel, colour and syncs three cycles after it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (monOn && expQ.size() > 0) begin
            check("addr", {24'd0, ifc.oCELL_ADDR}, {24'd0, expQ[expQ.size() - 1].addr});
            if (expQ.size() >= 3) begin
               monE = expQ.pop_front();
               check("rgb", {20'd0, ifc.oVGA_R, ifc.oVGA_G, ifc.oVGA_B}, {20'd0, monE.rgb});
               check("hs_vs_blank", {29'd0, ifc.oHS, ifc.oVS, ifc.oBLANK_n},
                     {29'd0, monE.hs, monE.vs, monE.bl});
            end
         end
      end
   end

   function automatic bit inBoard(int x, int y);
      return x >= 220 && x < 420 && y >= 40 && y < 440;
   endfunction

   function automatic bit inFrame(int x, int y);
      return !inBoard(x, y) && x >= 216 && x < 424 && y >= 36 && y < 444;
   endfunction

   function automatic int cellIdx(int x, int y);
      return ((y - 40) / 20) * 10 + (x - 220) / 20;
   endfunction

   function automatic logic [11:0] expRgb(logic b, int x, int y);
      logic [2:0] code;
      if (!b || !synced) return 12'h000;
      if (inFrame(x, y)) return 12'hAAA;
      if (!inBoard(x, y)) return 12'h000;
      code = cells[cellIdx(x, y)];
      if (code != 3'd0) return pal[code];
      if ((x - 220) % 20 == 19 || (y - 40) % 20 == 19) return 12'h222;
      return 12'h000;
   endfunction

   function automatic logic [7:0] expAddr(logic b, int x, int y);
      if (b && synced && inBoard(x, y)) return 8'(cellIdx(x, y));
      return 8'd0;
   endfunction

   task automatic pushExp(input logic b, input logic h, input logic v, input int x, input int y);
      exp_t e;
      e.rgb  = expRgb(b, x, y);
      e.addr = expAddr(b, x, y);
      e.hs   = h;
      e.vs   = v;
      e.bl   = b;
      expQ.push_back(e);
   endtask

   task automatic step(input logic b, input logic h, input logic v, input int x, input int y);
      @(negedge clk);
      ifc.iBLANK_n = b;
      ifc.iHS      = h;
      ifc.iVS      = v;
      if (!v) synced = 1'b1;
      pushExp(b, h, v, x, y);
   endtask

   // Called at a falling clock edge: the two reset-derived outputs lead the held pixel.
   task automatic releaseReset();
      exp_t r;
      rstN   = 1'b1;
      synced = 1'b0;
      expQ.delete();
      r.rgb  = 12'h000;
      r.hs   = 1'b1;
      r.vs   = 1'b1;
      r.bl   = 1'b0;
      r.addr = 8'd0;
      expQ.push_back(r);
      expQ.push_back(r);
      pushExp(ifc.iBLANK_n, ifc.iHS, ifc.iVS, -1, -1);
      monOn = 1'b1;
   endtask

   task automatic checkResetState(input string tag);
      check({tag, "_rgb"},  {20'd0, ifc.oVGA_R, ifc.oVGA_G, ifc.oVGA_B}, 32'h000);
      check({tag, "_hs"},   {31'd0, ifc.oHS}, 32'd1);
      check({tag, "_vs"},   {31'd0, ifc.oVS}, 32'd1);
      check({tag, "_blank"}, {31'd0, ifc.oBLANK_n}, 32'd0);
      check({tag, "_addr"}, {24'd0, ifc.oCELL_ADDR}, 32'd0);
   endtask

   task automatic midReset();
      monOn = 1'b0;
      #2 rstN = 1'b0;
      #1 checkResetState("midrst");
      @(posedge clk);
      #1 checkResetState("midrst_edge");
      @(negedge clk);
      @(negedge clk);
      releaseReset();
   endtask

   function automatic int lineLen(int y);
      if (y inside {0, 35, 36, 40, 45, 50, 59, 60, 100, 250, 439, 440, 443, 444}) return 640;
      if ($urandom_range(0, 31) == 0) return 430;
      return int'($urandom_range(1, 6));
   endfunction

   task automatic runLine(input int y, input int len, input int rstAt);
      for (int x = 0; x < len; x++) begin
         step(1'b1, 1'b1, 1'b1, x, y);
         if (x == rstAt) midReset();
      end
      step(1'b0, 1'b1, 1'b1, -1, y);
      step(1'b0, 1'b0, 1'b1, -1, y);
      step(1'b0, 1'b0, 1'b1, -1, y);
      step(1'b0, 1'b1, 1'b1, -1, y);
   endtask

   task automatic runFrame(input int nLines, input int rstLine);
      step(1'b0, 1'b1, 1'b1, -1, -1);
      step(1'b0, 1'b1, 1'b1, -1, -1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, -1, -1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, -1, -1);
      for (int y = 0; y < nLines; y++) begin
         if (y == rstLine) runLine(y, 640, 229);
         else              runLine(y, lineLen(y), -1);
      end
   endtask

   task automatic fillCells(input logic [2:0] first);
      for (int i = 0; i < 200; i++) cells[i] = 3'($urandom_range(0, 7));
      cells[0] = first;
   endtask

   initial begin
      pal[0] = 12'h000; pal[1] = 12'h0FF; pal[2] = 12'hFF0; pal[3] = 12'hF0F;
      pal[4] = 12'h0F0; pal[5] = 12'hF00; pal[6] = 12'h00F; pal[7] = 12'hF80;
      nCmp  = 0;
      nFail = 0;
      monOn = 1'b0;
      synced = 1'b0;
      rstN  = 1'b0;
      ifc.iBLANK_n = 1'b0;
      ifc.iHS      = 1'b1;
      ifc.iVS      = 1'b1;
      fillCells(3'd3);
      repeat (3) @(negedge clk);
      checkResetState("rst");
      releaseReset();

      runFrame(446, -1);
      fillCells(3'd0);
      runFrame(446, -1);
      fillCells(3'd5);
      runFrame(61, 50);
      runFrame(446, -1);

      repeat (6) step(1'b0, 1'b1, 1'b1, -1, -1);
      @(negedge clk);
      monOn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
